// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller for the 5-stage MIPS pipeline: detects load-use,
// ID-resolved redirects and data-memory waits, and drives the stage-register controls.
module hazard_flush_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadEX,
  input  logic [4:0]       RtEX,
  input  logic [4:0]       RsID,
  input  logic [4:0]       RtID,
  input  logic             UseRtID,
  input  logic             BranchTaken,
  input  logic             JumpID,
  input  logic             MemReqM,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IF_ID_write,
  output logic             IF_Flush,
  output logic             CtrlZero,
  output logic             Freeze,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemTimeout
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD_STALL,
    S_MEM_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_timeout;

  logic w_memwait;
  logic w_loaduse;
  logic w_redirect;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_timeout_hit;

  assign w_memwait  = MemReqM & ~MemReady;
  assign w_loaduse  = MemReadEX & (RtEX != 5'd0) &
                      ((RtEX == RsID) | (UseRtID & (RtEX == RtID)));
  assign w_redirect = BranchTaken | JumpID;

  // Counts the cycle of the access that first waits too, so the flag rises once
  // MEM_TIMEOUT consecutive wait cycles have elapsed.
  assign w_timeout_hit = (MEM_TIMEOUT != 0) && w_memwait && (r_wait >= TO_LAST);

  always_comb begin
    w_next      = r_state;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    PCWrite     = 1'b1;
    IF_ID_write = 1'b1;
    IF_Flush    = 1'b0;
    CtrlZero    = 1'b0;
    Freeze      = 1'b0;
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_write = 1'b0;
      IF_Flush    = 1'b1;
      CtrlZero    = 1'b1;
      w_next      = S_RUN;
    end else begin
      unique case (r_state)
        // MEM_WAIT shares RUN's decode: while waiting it yields the same freeze
        // outputs, and on the ready cycle it must apply RUN rules to current inputs.
        S_RUN, S_MEM_WAIT: begin
          if (w_memwait) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            Freeze      = 1'b1;
            w_stall_inc = 1'b1;
            w_next      = S_MEM_WAIT;
          end else if (w_loaduse) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            CtrlZero    = 1'b1;
            w_stall_inc = 1'b1;
            w_next      = S_LOAD_STALL;
          end else begin
            w_next = S_RUN;
            if (w_redirect) begin
              IF_Flush    = 1'b1;
              w_flush_inc = 1'b1;
            end
          end
        end
        S_LOAD_STALL: begin
          if (w_memwait) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            Freeze      = 1'b1;
            w_stall_inc = 1'b1;
            w_next      = S_MEM_WAIT;
          end else begin
            w_next = S_RUN;
            if (w_redirect) begin
              IF_Flush    = 1'b1;
              w_flush_inc = 1'b1;
            end
          end
        end
        default: w_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_memwait) begin
        if (r_wait != '1) r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
  assign MemTimeout = r_timeout;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: the driver queues hand-computed expectations
// per cycle; a monitor pops and compares them mid-cycle against one of two instances.
module tb_hazard_flush_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic MemReadEX, UseRtID, BranchTaken, JumpID, MemReqM, MemReady;
  logic [4:0] RtEX, RsID, RtID;

  logic a_pcw, a_ifw, a_fl, a_cz, a_frz, a_to;
  logic [15:0] a_sc, a_fc;
  logic b_pcw, b_ifw, b_fl, b_cz, b_frz, b_to;
  logic [1:0] b_sc, b_fc;

  typedef struct {
    bit sel;
    bit pcw, ifw, fl, cz, frz, to;
    int sc, fc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) u_dut_a (
    .clk(clk), .rst(rst), .MemReadEX(MemReadEX), .RtEX(RtEX), .RsID(RsID), .RtID(RtID),
    .UseRtID(UseRtID), .BranchTaken(BranchTaken), .JumpID(JumpID), .MemReqM(MemReqM),
    .MemReady(MemReady), .PCWrite(a_pcw), .IF_ID_write(a_ifw), .IF_Flush(a_fl),
    .CtrlZero(a_cz), .Freeze(a_frz), .StallCount(a_sc), .FlushCount(a_fc), .MemTimeout(a_to)
  );

  hazard_flush_ctrl #(.CNT_W(2), .MEM_TIMEOUT(3)) u_dut_b (
    .clk(clk), .rst(rst), .MemReadEX(MemReadEX), .RtEX(RtEX), .RsID(RsID), .RtID(RtID),
    .UseRtID(UseRtID), .BranchTaken(BranchTaken), .JumpID(JumpID), .MemReqM(MemReqM),
    .MemReady(MemReady), .PCWrite(b_pcw), .IF_ID_write(b_ifw), .IF_Flush(b_fl),
    .CtrlZero(b_cz), .Freeze(b_frz), .StallCount(b_sc), .FlushCount(b_fc), .MemTimeout(b_to)
  );

  task automatic chk(input string nm, input int cyc, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation in the middle of the low phase.
  int mon_cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("A.PCWrite",     mon_cyc, int'(a_pcw), int'(e.pcw));
          chk("A.IF_ID_write", mon_cyc, int'(a_ifw), int'(e.ifw));
          chk("A.IF_Flush",    mon_cyc, int'(a_fl),  int'(e.fl));
          chk("A.CtrlZero",    mon_cyc, int'(a_cz),  int'(e.cz));
          chk("A.Freeze",      mon_cyc, int'(a_frz), int'(e.frz));
          chk("A.StallCount",  mon_cyc, int'(a_sc),  e.sc);
          chk("A.FlushCount",  mon_cyc, int'(a_fc),  e.fc);
          chk("A.MemTimeout",  mon_cyc, int'(a_to),  int'(e.to));
        end else begin
          chk("B.PCWrite",     mon_cyc, int'(b_pcw), int'(e.pcw));
          chk("B.IF_ID_write", mon_cyc, int'(b_ifw), int'(e.ifw));
          chk("B.IF_Flush",    mon_cyc, int'(b_fl),  int'(e.fl));
          chk("B.CtrlZero",    mon_cyc, int'(b_cz),  int'(e.cz));
          chk("B.Freeze",      mon_cyc, int'(b_frz), int'(e.frz));
          chk("B.StallCount",  mon_cyc, int'(b_sc),  e.sc);
          chk("B.FlushCount",  mon_cyc, int'(b_fc),  e.fc);
          chk("B.MemTimeout",  mon_cyc, int'(b_to),  int'(e.to));
        end
      end
      mon_cyc++;
    end
  end

  task automatic setin(input bit mr, input int rtex, input int rs, input int rt, input bit urt,
                       input bit br, input bit j, input bit mreq, input bit mrdy);
    MemReadEX   = mr;
    RtEX        = 5'(rtex);
    RsID        = 5'(rs);
    RtID        = 5'(rt);
    UseRtID     = urt;
    BranchTaken = br;
    JumpID      = j;
    MemReqM     = mreq;
    MemReady    = mrdy;
  endtask

  task automatic idle();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic memwait();
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic push(input bit sel, input bit pcw, input bit ifw, input bit fl, input bit cz,
                      input bit frz, input int sc, input int fc, input bit to);
    exp_t e;
    e.sel = sel; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.cz = cz; e.frz = frz;
    e.sc = sc; e.fc = fc; e.to = to;
    q.push_back(e);
  endtask

  initial begin
    idle();
    // reset held
    @(negedge clk); idle(); push(0, 0,0,1,1,0, 0,0,0); push(1, 0,0,1,1,0, 0,0,0);
    @(negedge clk); rst = 1'b0; idle(); push(0, 1,1,0,0,0, 0,0,0);
    // load-use on rs, then bubble cycle
    @(negedge clk); setin(1, 8, 8, 0, 0, 0, 0, 0, 1); push(0, 0,0,0,1,0, 0,0,0);
    @(negedge clk); idle();                            push(0, 1,1,0,0,0, 1,0,0);
    // register 0 never stalls
    @(negedge clk); setin(1, 0, 0, 0, 0, 0, 0, 0, 1); push(0, 1,1,0,0,0, 1,0,0);
    // rt match only counts when UseRtID
    @(negedge clk); setin(1, 9, 3, 9, 0, 0, 0, 0, 1); push(0, 1,1,0,0,0, 1,0,0);
    @(negedge clk); setin(1, 9, 3, 9, 1, 0, 0, 0, 1); push(0, 0,0,0,1,0, 1,0,0);
    @(negedge clk); idle();                            push(0, 1,1,0,0,0, 2,0,0);
    // taken branch alone
    @(negedge clk); setin(0, 0, 0, 0, 0, 1, 0, 0, 1); push(0, 1,1,1,0,0, 2,0,0);
    @(negedge clk); idle();                            push(0, 1,1,0,0,0, 2,1,0);
    // branch with load-use: stall first, flush next cycle
    @(negedge clk); setin(1, 8, 8, 0, 0, 1, 0, 0, 1); push(0, 0,0,0,1,0, 2,1,0);
    @(negedge clk); setin(0, 0, 0, 0, 0, 1, 0, 0, 1); push(0, 1,1,1,0,0, 3,1,0);
    @(negedge clk); idle();                            push(0, 1,1,0,0,0, 3,2,0);
    // four memory wait cycles, then ready
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); memwait(); push(0, 0,0,0,0,1, 3 + i,2,0);
    end
    @(negedge clk); setin(0, 0, 0, 0, 0, 0, 0, 1, 1); push(0, 1,1,0,0,0, 7,2,0);
    // jump alone
    @(negedge clk); setin(0, 0, 0, 0, 0, 0, 1, 0, 1); push(0, 1,1,1,0,0, 7,2,0);
    @(negedge clk); idle();                            push(0, 1,1,0,0,0, 7,3,0);
    // reset asserted mid MEM_WAIT
    @(negedge clk); memwait();            push(0, 0,0,0,0,1, 7,3,0);
    @(negedge clk); memwait();            push(0, 0,0,0,0,1, 8,3,0);
    @(negedge clk); rst = 1'b1; memwait(); push(0, 0,0,1,1,0, 0,0,0); push(1, 0,0,1,1,0, 0,0,0);
    @(negedge clk); rst = 1'b0; idle();   push(0, 1,1,0,0,0, 0,0,0); push(1, 1,1,0,0,0, 0,0,0);
    // timeout and saturation on instance B (CNT_W=2, MEM_TIMEOUT=3)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); memwait(); push(1, 0,0,0,0,1, (i > 3) ? 3 : i, 0, i >= 3);
    end
    @(negedge clk); setin(0, 0, 0, 0, 0, 0, 0, 1, 1); push(1, 1,1,0,0,0, 3,0,1);
    @(negedge clk); idle(); push(1, 1,1,0,0,0, 3,0,1); push(0, 1,1,0,0,0, 5,0,0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline control unit that drives the write-enable, flush and bubble controls of the inter-stage registers in the 5-stage MIPS pipeline.
- Detects load-use hazards, taken branches/jumps resolved in ID, and multi-cycle data-memory waits.
- Sequences the resulting stalls and flushes with a small state machine, and keeps saturating event counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16: width of the stall and flush event counters.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before the error flag sets; 0 disables the check.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- MemReadEX  in  1  instruction in EX is a load (ID/EX M-control).
- RtEX  in  5  load destination register in EX.
- RsID  in  5  rs field of the instruction in ID.
- RtID  in  5  rt field of the instruction in ID.
- UseRtID  in  1  ID instruction reads rt as a source.
- BranchTaken  in  1  branch resolved taken in ID this cycle.
- JumpID  in  1  jump decoded in ID this cycle.
- MemReqM  in  1  load or store present in M stage.
- MemReady  in  1  data memory completes the M-stage access this cycle.
- PCWrite  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID register write enable.
- IF_Flush  out  1  replace IF/ID instruction with NOP.
- CtrlZero  out  1  force zero WB/M/EX controls into ID/EX (bubble).
- Freeze  out  1  hold ID/EX, EX/M and M/WB registers.
- StallCount  out  CNT_W  saturating count of stall cycles.
- FlushCount  out  CNT_W  saturating count of flush events.
- MemTimeout  out  1  sticky error flag.

Behaviour:
- State register: RUN, LOAD_STALL, MEM_WAIT. The only storage is the state register, the wait counter, both event counters and MemTimeout. All outputs are Mealy combinational from state and inputs.
- Reset (asynchronous, any cycle, including mid-stall):
  - State goes to RUN; counters and MemTimeout clear to 0.
  - While rst=1: PCWrite=0, IF_ID_write=0, IF_Flush=1, CtrlZero=1, Freeze=0.
- Conditions:
  - memwait = MemReqM & ~MemReady.
  - loaduse = MemReadEX & (RtEX!=0) & ((RtEX==RsID) | (UseRtID & RtEX==RtID)).
  - redirect = BranchTaken | JumpID.
- Priority: memwait > loaduse > redirect.
- Defaults (no event): PCWrite=1, IF_ID_write=1, IF_Flush=0, CtrlZero=0, Freeze=0.
- RUN:
  - If memwait: PCWrite=0, IF_ID_write=0, Freeze=1; next state MEM_WAIT; StallCount+1.
  - Else if loaduse: PCWrite=0, IF_ID_write=0, CtrlZero=1; next state LOAD_STALL; StallCount+1. A redirect in the same cycle is ignored and re-evaluated next cycle.
  - Else if redirect: IF_Flush=1 for exactly this cycle, PCWrite=1, IF_ID_write=1; FlushCount+1; stay in RUN.
- LOAD_STALL (exactly one cycle):
  - loaduse is not re-evaluated; the bubble guarantees MemReadEX=0.
  - If memwait: behave as RUN memwait and go to MEM_WAIT.
  - Else if redirect: flush as in RUN and go to RUN.
  - Else: defaults, go to RUN.
- MEM_WAIT:
  - Freeze=1, PCWrite=0, IF_ID_write=0, IF_Flush=0, CtrlZero=0 while memwait.
  - StallCount+1 per cycle; wait counter +1 per cycle.
  - On the first cycle with MemReady=1 (or MemReqM=0): outputs as in RUN evaluated on this cycle's inputs; next state per RUN rules; wait counter clears.
  - When MEM_TIMEOUT!=0 and the wait counter reaches MEM_TIMEOUT: MemTimeout sets and stays 1 until rst. The stall continues; the block never forces progress.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- IF_Flush and Freeze are never both 1. PCWrite=0 implies IF_ID_write=0.
- Register 0 never causes a load-use stall.

Test Plan:
- Reset pulse mid-MEM_WAIT -> PCWrite=0, IF_Flush=1, CtrlZero=1 immediately; after release, state RUN, StallCount=0, MemTimeout=0.
- MemReadEX=1, RtEX=8, RsID=8 -> one cycle with PCWrite=0, IF_ID_write=0, CtrlZero=1; next cycle defaults; StallCount=1. Repeat with RtEX=0 -> no stall.
- RtEX=9=RtID with UseRtID=0 -> no stall; with UseRtID=1 -> 1-cycle stall.
- BranchTaken=1 alone -> IF_Flush=1 for one cycle, PCWrite=1, FlushCount=1. BranchTaken together with loaduse -> stall first, then flush on the following cycle; totals StallCount=1, FlushCount=1.
- MemReqM=1, MemReady=0 for 4 cycles then 1 -> Freeze=1 and PCWrite=0 for 4 cycles, StallCount=4, Freeze=0 on the ready cycle.
- MEM_TIMEOUT=3, MemReady held 0 for 5 cycles -> MemTimeout=1 after the 3rd wait cycle and stays 1 after ready. With CNT_W=2, 5 stall cycles -> StallCount=3 (saturated).
